// File: rtl/calc_pkg.sv
// Shared types and operand limits for the sum/difference board's decimal entry path.
package calc_pkg;

  typedef enum logic [1:0] {
    S_TENS  = 2'd0,
    S_ONES  = 2'd1,
    S_CHECK = 2'd2
  } entry_state_t;

  localparam int OPERAND_W = 6;
  // Two BCD digits give at most 99, which needs 7 bits of magnitude.
  localparam int MAG_W     = 7;
  localparam int BCD_MAX   = 9;

  function automatic int max_pos(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int max_neg_mag(input int w);
    return 1 << (w - 1);
  endfunction

  localparam int MAX_POS     = max_pos(OPERAND_W);
  localparam int MAX_NEG_MAG = max_neg_mag(OPERAND_W);

endpackage

// File: rtl/press_edge.sv
// Two-flop synchronizer for the active-low pushbutton plus a registered one-shot
// that fires once per synchronized 1->0 transition.
module press_edge (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Flops idle high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      press   <= prev_p2 & ~sync_p1;
    end
  end

endmodule

// File: rtl/dec_entry.sv
// Decimal operand entry: two button presses capture tens and ones BCD digits,
// the signed result is range-checked and emitted as a W-bit two's-complement operand.
module dec_entry
  import calc_pkg::*;
#(
  parameter int W = OPERAND_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         button,
  input  logic [3:0]   digit,
  input  logic         neg,
  output logic [W-1:0] value,
  output logic         valid,
  output logic         err,
  output logic [3:0]   tens_q,
  output logic [3:0]   ones_q,
  output logic         phase
);

  localparam int EXT_W = (W > MAG_W) ? W : MAG_W;
  localparam logic [MAG_W-1:0] LIM_POS = MAG_W'(max_pos(W));
  localparam logic [MAG_W-1:0] LIM_NEG = MAG_W'(max_neg_mag(W));
  localparam logic [3:0]       BCD_LIM = 4'(BCD_MAX);

  entry_state_t     state;
  logic             press;
  logic             neg_q;
  logic [MAG_W-1:0] mag;

  function automatic logic [MAG_W-1:0] times10(input logic [3:0] t);
    return MAG_W'({t, 3'b000}) + MAG_W'({t, 1'b0});
  endfunction

  function automatic logic in_range(input logic [3:0] t, input logic [3:0] o,
                                    input logic n, input logic [MAG_W-1:0] m);
    return (t <= BCD_LIM) && (o <= BCD_LIM) && (n ? (m <= LIM_NEG) : (m <= LIM_POS));
  endfunction

  // Negative zero falls out naturally: -0 == 0.
  function automatic logic [W-1:0] to_twos(input logic n, input logic [MAG_W-1:0] m);
    logic signed [EXT_W:0] ext;
    ext = $signed({{(EXT_W + 1 - MAG_W){1'b0}}, m});
    if (n) ext = -ext;
    return ext[W-1:0];
  endfunction

  press_edge u_press_edge (
    .clk    (clk),
    .reset  (reset),
    .button (button),
    .press  (press)
  );

  assign mag = times10(tens_q) + MAG_W'(ones_q);

  // Entry FSM: capture digits, then judge and publish in S_CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_TENS;
      value  <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
      tens_q <= '0;
      ones_q <= '0;
      neg_q  <= 1'b0;
      phase  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_TENS: begin
          if (press) begin
            tens_q <= digit;
            ones_q <= '0;
            err    <= 1'b0;
            state  <= S_ONES;
            phase  <= 1'b1;
          end
        end
        S_ONES: begin
          if (press) begin
            ones_q <= digit;
            neg_q  <= neg;
            state  <= S_CHECK;
            phase  <= 1'b0;
          end
        end
        S_CHECK: begin
          // Any press landing here is intentionally dropped.
          if (in_range(tens_q, ones_q, neg_q, mag)) begin
            value <= to_twos(neg_q, mag);
            valid <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          state <= S_TENS;
        end
        default: begin
          state <= S_TENS;
          phase <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dec_entry.md
# dec_entry

Decimal operand entry for the sum/difference board: the inverse of the display path, which turns a 6-bit two's-complement value into sign, tens and ones digits. This block takes a sign switch, a 4-bit BCD digit switch bank and a pushbutton. From two presses it assembles a tens digit and a ones digit, range-checks the signed result and emits a 6-bit two's-complement operand with a one-cycle valid strobe. It sits between the board switches and the adder/subtractor operand inputs. The captured digits are also exported for the hex displays.

## Interface
- `W`, default 6: operand width; legal range is −2^(W−1) .. 2^(W−1)−1, i.e. −32..31.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `button` input 1: raw pushbutton, active-low, asynchronous to `clk`.
- `digit` input 4: BCD digit switches, sampled on a press.
- `neg` input 1: sign switch (1 = negative), sampled on the ones press.
- `value` output W: last accepted operand, two's complement. Holds until the next accepted entry.
- `valid` output 1: one-cycle pulse when `value` updates.
- `err` output 1: last entry rejected. Level signal.
- `tens_q` output 4: captured tens digit, for display.
- `ones_q` output 4: captured ones digit, for display.
- `phase` output 1: 0 = awaiting tens press, 1 = awaiting ones press. Drives an LED.

## Operation
- Press detection:
  - `button` passes through a 2-flop synchronizer.
  - A press is the synchronized 1→0 transition. It produces exactly one `press` pulse, however long the button is held.
  - There is no debounce; the board buttons are already debounced.
- FSM states: `S_TENS` (reset state), `S_ONES`, `S_CHECK`.
- `S_TENS` + press:
  - `tens_q` ← `digit`, `ones_q` ← 0, `err` ← 0.
  - Go to `S_ONES`.
- `S_ONES` + press:
  - `ones_q` ← `digit`; `neg` is latched.
  - Go to `S_CHECK`.
- `S_CHECK`: unconditionally returns to `S_TENS` after one cycle. In that cycle it computes:
  - mag = `tens_q`·10 + `ones_q`, 7 bits unsigned.
  - Reject if `tens_q` > 9, or `ones_q` > 9, or (`neg`=0 and mag > 31), or (`neg`=1 and mag > 32).
  - Reject: `err` ← 1; `value` and `valid` unchanged.
  - Accept: `value` ← `neg` ? −mag : mag, truncated to W bits; `valid` ← 1 for one cycle.
  - Negative zero (`neg`=1, mag=0) is accepted as 0.
  - −32 is accepted as 6'b100000.
- Invalid tens digits (>3 but ≤9) are not rejected at capture. Rejection happens only in `S_CHECK`, via the magnitude rule.
- A press arriving while in `S_CHECK` is dropped. It is not queued.
- `phase` = 1 exactly when the state is `S_ONES`.

## Timing
- Reset values:
  - `value` = 0, `valid` = 0, `err` = 0, `tens_q` = 0, `ones_q` = 0, `phase` = 0.
  - State = `S_TENS`; synchronizer flops = 1 (button released).
- Reset mid-entry (in `S_ONES` or `S_CHECK`) abandons the entry with no `valid` pulse.
- Press latency: take edge k as the first rising edge that samples `button` low. The `press` pulse is high for the cycle after edge k+2. The digit is captured on edge k+3.
- Ones capture on edge n → `S_CHECK` during cycle n..n+1 → `value` and `valid` (or `err`) register on edge n+1.
- `valid` is high from edge n+1 to edge n+2.
- `value` never changes except on the same edge that raises `valid`.
- `err` rises on edge n+1 and clears on the edge that captures the next tens digit.

## Structure
- Package `calc_pkg` holds:
  - the state enum `entry_state_t`;
  - constants `MAX_POS` = 31 and `MAX_NEG_MAG` = 32, both derived from W;
  - the constant `BCD_MAX` = 9.
- One sub-module, `press_edge`: the 2-flop synchronizer plus falling-edge pulse generator, with its own `reset`.
- The multiply-by-10 is done as (t<<3)+(t<<1). No multiplier is inferred.

## Test plan
- Positive entry: reset; press with `digit`=2; press with `digit`=7, `neg`=0 → `value`=6'b011011 (27); `valid` is a single-cycle pulse; `err`=0.
- Negative extreme: tens 3, ones 2, `neg`=1 → `value`=6'b100000 (−32). Then tens 3, ones 2, `neg`=0 → `err`=1 and `value` stays at −32.
- Bad digit: tens 0, ones 4'hC → `err`=1 with no `valid`. The next tens press clears `err`. Negative zero (tens 0, ones 0, `neg`=1) → `value`=0 and `valid` pulses.
- Held and bouncy press: hold `button` low for 50 cycles → one capture only, `phase` goes 0→1. Release and press again → ones capture, then `valid`.
- Reset mid-entry: press tens 1, assert `reset` for one cycle in `S_ONES` → all outputs return to reset values. The next press is treated as a tens press.
- Latency check: drive `button` low at a known edge k → `tens_q` updates on edge k+3. For ones captured on edge n, `valid` is observed high only between edges n+1 and n+2.
